// File: rtl/traffic_phase_ctrl_module_if.sv
// Control inputs and lamp/countdown outputs of the traffic phase controller.
interface traffic_phase_ctrl_module_if;
    logic       Night_Mode;
    logic       Hold;
    logic [2:0] NS_Light;
    logic [2:0] EW_Light;
    logic [3:0] Ten_Data;
    logic [3:0] One_Data;
    logic       Sec_Tick;

    // Side that drives the mode inputs and observes the lamps/digits.
    modport master (
        output Night_Mode,
        output Hold,
        input  NS_Light,
        input  EW_Light,
        input  Ten_Data,
        input  One_Data,
        input  Sec_Tick
    );

    // Controller side.
    modport slave (
        input  Night_Mode,
        input  Hold,
        output NS_Light,
        output EW_Light,
        output Ten_Data,
        output One_Data,
        output Sec_Tick
    );
endinterface

// File: rtl/traffic_phase_ctrl_module.sv
// Two-direction intersection sequencer: seconds prescaler, four-phase FSM with
// BCD countdown, flashing-yellow night mode and a hold freeze.
module traffic_phase_ctrl_module #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned GREEN_TIME  = 30,
    parameter int unsigned YELLOW_TIME = 3
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    traffic_phase_ctrl_module_if.slave   bus
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    // Phase times converted to BCD at elaboration.
    localparam logic [3:0] G_TENS = 4'(GREEN_TIME / 10);
    localparam logic [3:0] G_ONES = 4'(GREEN_TIME % 10);
    localparam logic [3:0] Y_TENS = 4'(YELLOW_TIME / 10);
    localparam logic [3:0] Y_ONES = 4'(YELLOW_TIME % 10);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_EW_GREEN  = 3'd2,
        S_EW_YELLOW = 3'd3,
        S_NIGHT     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             flash_q, flash_d;
    logic [2:0]       ns_q, ns_d;
    logic [2:0]       ew_q, ew_d;
    logic [3:0]       ten_out_q, ten_out_d;
    logic [3:0]       one_out_q, one_out_d;
    logic             sec_tick_q, sec_tick_d;

    logic             pre_wrap_c;
    logic             tick_c;

    assign pre_wrap_c = (pre_q == PRE_MAX);

    // Next-state: night entry/exit first, then hold freeze, then normal countdown.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        pre_d   = pre_q;
        flash_d = flash_q;
        tick_c  = 1'b0;

        if (bus.Night_Mode) begin
            if (state_q != S_NIGHT) begin
                // Entry discards any coincident tick.
                state_d = S_NIGHT;
                pre_d   = '0;
                flash_d = 1'b1;
            end else begin
                tick_c = pre_wrap_c;
                pre_d  = pre_wrap_c ? '0 : PRE_W'(pre_q + 1'b1);
                if (pre_wrap_c) begin
                    flash_d = ~flash_q;
                end
            end
        end else if (state_q == S_NIGHT) begin
            state_d = S_NS_GREEN;
            tens_d  = G_TENS;
            ones_d  = G_ONES;
            pre_d   = '0;
            flash_d = 1'b0;
        end else if (!bus.Hold) begin
            tick_c = pre_wrap_c;
            pre_d  = pre_wrap_c ? '0 : PRE_W'(pre_q + 1'b1);
            if (pre_wrap_c) begin
                if (tens_q == 4'd0 && ones_q == 4'd1) begin
                    case (state_q)
                        S_NS_GREEN: begin
                            state_d = S_NS_YELLOW;
                            tens_d  = Y_TENS;
                            ones_d  = Y_ONES;
                        end
                        S_NS_YELLOW: begin
                            state_d = S_EW_GREEN;
                            tens_d  = G_TENS;
                            ones_d  = G_ONES;
                        end
                        S_EW_GREEN: begin
                            state_d = S_EW_YELLOW;
                            tens_d  = Y_TENS;
                            ones_d  = Y_ONES;
                        end
                        default: begin
                            state_d = S_NS_GREEN;
                            tens_d  = G_TENS;
                            ones_d  = G_ONES;
                        end
                    endcase
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // Output decode from the current state/counter, registered below.
    always_comb begin
        ns_d       = LAMP_RED;
        ew_d       = LAMP_RED;
        ten_out_d  = tens_q;
        one_out_d  = ones_q;
        sec_tick_d = tick_c;
        case (state_q)
            S_NS_GREEN:  ns_d = LAMP_GRN;
            S_NS_YELLOW: ns_d = LAMP_YEL;
            S_EW_GREEN:  ew_d = LAMP_GRN;
            S_EW_YELLOW: ew_d = LAMP_YEL;
            S_NIGHT: begin
                ns_d      = flash_q ? LAMP_YEL : LAMP_OFF;
                ew_d      = flash_q ? LAMP_YEL : LAMP_OFF;
                ten_out_d = 4'd0;
                one_out_d = 4'd0;
            end
            default: begin
                ns_d = LAMP_RED;
                ew_d = LAMP_RED;
            end
        endcase
    end

    // State, counter, prescaler and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_NS_GREEN;
            tens_q     <= G_TENS;
            ones_q     <= G_ONES;
            pre_q      <= '0;
            flash_q    <= 1'b0;
            ns_q       <= LAMP_RED;
            ew_q       <= LAMP_RED;
            ten_out_q  <= 4'd0;
            one_out_q  <= 4'd0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            pre_q      <= pre_d;
            flash_q    <= flash_d;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
            ten_out_q  <= ten_out_d;
            one_out_q  <= one_out_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign bus.NS_Light = ns_q;
    assign bus.EW_Light = ew_q;
    assign bus.Ten_Data = ten_out_q;
    assign bus.One_Data = one_out_q;
    assign bus.Sec_Tick = sec_tick_q;

endmodule
